// File: rtl/mem_sram_arbiter.sv
// Round-robin two-port front end for a single-port SRAM: zero-fills the array
// after reset, then grants one access per cycle with a fixed 1-cycle read latency.
module mem_sram_arbiter #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 8,
    parameter int unsigned addr  = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [addr-1:0]  addr0,
    input  logic [addr-1:0]  addr1,
    input  logic [width-1:0] data0,
    input  logic [width-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [width-1:0] q0,
    output logic [width-1:0] q1,
    output logic             init_done,
    output logic             mem_WE,
    output logic [addr-1:0]  mem_Address,
    output logic [width-1:0] mem_Data,
    input  logic [width-1:0] mem_Q
);
    localparam int unsigned AW       = addr;
    localparam int unsigned DW       = width;
    localparam int unsigned LAST_IDX = depth - 1;

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic          active_q, active_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          init_done_q, init_done_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] q0_q, q0_d;
    logic [DW-1:0] q1_q, q1_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          in_range0, in_range1;

    // last_q = 1 means port 1 was granted most recently, so port 0 wins a tie.
    always_comb begin
        state_d     = state_q;
        active_d    = 1'b1;
        cnt_d       = cnt_q;
        last_d      = last_q;
        init_done_d = init_done_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        q0_d        = q0_q;
        q1_d        = q1_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        mem_WE      = 1'b0;
        mem_Address = hold_addr_q;
        mem_Data    = hold_data_q;
        in_range0   = (32'(addr0) < depth);
        in_range1   = (32'(addr1) < depth);

        if (state_q == S_INIT) begin
            // active_q keeps the SRAM quiet until the first edge after reset release
            if (active_q) begin
                mem_WE      = 1'b1;
                mem_Address = cnt_q;
                mem_Data    = '0;
                if (32'(cnt_q) == LAST_IDX) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
        end else begin
            gnt0 = req0 & (~req1 | last_q);
            gnt1 = req1 & ~gnt0;
            if (gnt0) begin
                mem_WE      = we0 & in_range0;
                mem_Address = addr0;
                mem_Data    = data0;
                last_d      = 1'b0;
                rvalid0_d   = ~we0;
                if (!we0) begin
                    q0_d = in_range0 ? mem_Q : '0;
                end
            end else if (gnt1) begin
                mem_WE      = we1 & in_range1;
                mem_Address = addr1;
                mem_Data    = data1;
                last_d      = 1'b1;
                rvalid1_d   = ~we1;
                if (!we1) begin
                    q1_d = in_range1 ? mem_Q : '0;
                end
            end
        end

        hold_addr_d = mem_Address;
        hold_data_d = mem_Data;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_INIT;
            active_q    <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            init_done_q <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            q0_q        <= '0;
            q1_q        <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            init_done_q <= init_done_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign init_done = init_done_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign q0        = q0_q;
    assign q1        = q1_q;

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// Bench for mem_sram_arbiter: table-driven arbitration vectors with a read-data
// scoreboard, plus hand sequences for zero-fill, reset mid-read and depth=6.
module tb_mem_sram_arbiter;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned A  = 3;
    localparam int unsigned DB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A (depth 8)
    logic         rst_n;
    logic         req0, req1, we0, we1;
    logic [A-1:0] addr0, addr1;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, rvalid0, rvalid1, init_done, mem_WE;
    logic [W-1:0] q0, q1, mem_Data, mem_Q;
    logic [A-1:0] mem_Address;
    logic [W-1:0] sram_a [0:7];
    logic         seeded_a = 1'b0;

    // DUT B (depth 6)
    logic         rst_b_n;
    logic         b_req0, b_req1, b_we0, b_we1;
    logic [A-1:0] b_addr0, b_addr1;
    logic [W-1:0] b_data0, b_data1;
    logic         b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_init_done, b_mem_WE;
    logic [W-1:0] b_q0, b_q1, b_mem_Data, b_mem_Q;
    logic [A-1:0] b_mem_Address;
    logic [W-1:0] sram_b [0:7];
    logic         seeded_b = 1'b0;

    mem_sram_arbiter #(.width(W), .depth(D), .addr(A)) u_dut (
        .Clock(clk), .Reset_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .q0(q0), .q1(q1), .init_done(init_done),
        .mem_WE(mem_WE), .mem_Address(mem_Address), .mem_Data(mem_Data), .mem_Q(mem_Q)
    );

    mem_sram_arbiter #(.width(W), .depth(DB), .addr(A)) u_dut_b (
        .Clock(clk), .Reset_n(rst_b_n),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .data0(b_data0), .data1(b_data1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .q0(b_q0), .q1(b_q1), .init_done(b_init_done),
        .mem_WE(b_mem_WE), .mem_Address(b_mem_Address), .mem_Data(b_mem_Data), .mem_Q(b_mem_Q)
    );

    // SRAM models: filled with 8'hEE on the first edge so zero-fill is observable
    always @(posedge clk) begin
        if (!seeded_a) begin
            for (int i = 0; i < 8; i++) sram_a[i] <= 8'hEE;
            seeded_a <= 1'b1;
        end else if (mem_WE) begin
            sram_a[mem_Address] <= mem_Data;
        end
    end
    assign mem_Q = sram_a[mem_Address];

    always @(posedge clk) begin
        if (!seeded_b) begin
            for (int i = 0; i < 8; i++) sram_b[i] <= 8'hEE;
            seeded_b <= 1'b1;
        end else if (b_mem_WE) begin
            sram_b[b_mem_Address] <= b_mem_Data;
        end
    end
    assign b_mem_Q = sram_b[b_mem_Address];

    typedef struct {
        logic         r0, w0;
        logic [A-1:0] a0;
        logic [W-1:0] d0;
        logic         r1, w1;
        logic [A-1:0] a1;
        logic [W-1:0] d1;
        logic         g0, g1;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] ref_mem [0:7];
    logic [W-1:0] exp_q0 [$];
    logic [W-1:0] exp_q1 [$];
    logic         rv0_due = 1'b0;
    logic         rv1_due = 1'b0;
    logic [W-1:0] xq0_hold = '0;
    logic [W-1:0] xq1_hold = '0;
    logic [A-1:0] hold_a = '0;
    logic [W-1:0] hold_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r0, input logic w0, input logic [A-1:0] a0,
                                input logic [W-1:0] d0, input logic r1, input logic w1,
                                input logic [A-1:0] a1, input logic [W-1:0] d1,
                                input logic g0, input logic g1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    // One RUN cycle on DUT A: drive, check the combinational grant/SRAM pins, update model
    task automatic step(input vec_t v);
        logic [A-1:0] ea;
        logic [W-1:0] ed;
        logic         ewe;
        @(negedge clk);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; data0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; data1 = v.d1;
        #1;
        chk("gnt0", 32'(gnt0), 32'(v.g0));
        chk("gnt1", 32'(gnt1), 32'(v.g1));
        if (v.g0) begin
            ea = v.a0; ed = v.d0; ewe = v.w0 && (32'(v.a0) < D);
        end else if (v.g1) begin
            ea = v.a1; ed = v.d1; ewe = v.w1 && (32'(v.a1) < D);
        end else begin
            ea = hold_a; ed = hold_d; ewe = 1'b0;
        end
        chk("mem_WE", 32'(mem_WE), 32'(ewe));
        chk("mem_Address", 32'(mem_Address), 32'(ea));
        chk("mem_Data", 32'(mem_Data), 32'(ed));
        hold_a = ea;
        hold_d = ed;
        if (v.g0) begin
            if (v.w0) begin
                if (32'(v.a0) < D) ref_mem[v.a0] = v.d0;
            end else begin
                exp_q0.push_back((32'(v.a0) < D) ? ref_mem[v.a0] : '0);
                rv0_due = 1'b1;
            end
        end
        if (v.g1) begin
            if (v.w1) begin
                if (32'(v.a1) < D) ref_mem[v.a1] = v.d1;
            end else begin
                exp_q1.push_back((32'(v.a1) < D) ? ref_mem[v.a1] : '0);
                rv1_due = 1'b1;
            end
        end
    endtask

    // Zero-fill window on DUT A: exactly D cycles of writes 0..D-1 with no grants
    task automatic run_init();
        for (int i = 0; i < int'(D); i++) begin
            @(negedge clk);
            #1;
            chk("init mem_WE", 32'(mem_WE), 32'd1);
            chk("init mem_Address", 32'(mem_Address), 32'(i));
            chk("init mem_Data", 32'(mem_Data), 32'd0);
            chk("init gnt0", 32'(gnt0), 32'd0);
            chk("init gnt1", 32'(gnt1), 32'd0);
            chk("init init_done", 32'(init_done), 32'd0);
        end
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        hold_a = A'(D - 1);
        hold_d = '0;
    endtask

    // Read-return monitor for DUT A: rvalid timing, scoreboard data, q hold
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        chk("rvalid0", 32'(rvalid0), 32'(rv0_due));
        chk("rvalid1", 32'(rvalid1), 32'(rv1_due));
        rv0_due = 1'b0;
        rv1_due = 1'b0;
        if (rvalid0 && exp_q0.size() != 0) begin
            e = exp_q0.pop_front();
            chk("q0", 32'(q0), 32'(e));
            xq0_hold = e;
        end else if (!rvalid0) begin
            chk("q0 hold", 32'(q0), 32'(xq0_hold));
        end
        if (rvalid1 && exp_q1.size() != 0) begin
            e = exp_q1.pop_front();
            chk("q1", 32'(q1), 32'(e));
            xq1_hold = e;
        end else if (!rvalid1) begin
            chk("q1 hold", 32'(q1), 32'(xq1_hold));
        end
    end

    vec_t vt [17];

    initial begin
        vt[0]  = mk(1,1,3'd3,8'hA5, 0,0,3'd0,8'h00, 1,0);
        vt[1]  = mk(0,0,3'd0,8'h00, 1,0,3'd3,8'h00, 0,1);
        vt[2]  = mk(1,1,3'd1,8'h11, 0,0,3'd0,8'h00, 1,0);
        vt[3]  = mk(0,0,3'd0,8'h00, 1,1,3'd2,8'h22, 0,1);
        vt[4]  = mk(1,0,3'd1,8'h00, 1,0,3'd2,8'h00, 1,0);
        vt[5]  = mk(1,0,3'd1,8'h00, 1,0,3'd2,8'h00, 0,1);
        vt[6]  = mk(1,0,3'd1,8'h00, 1,0,3'd2,8'h00, 1,0);
        vt[7]  = mk(1,0,3'd1,8'h00, 1,0,3'd2,8'h00, 0,1);
        vt[8]  = mk(1,0,3'd1,8'h00, 1,0,3'd2,8'h00, 1,0);
        vt[9]  = mk(1,0,3'd1,8'h00, 1,0,3'd2,8'h00, 0,1);
        vt[10] = mk(1,1,3'd5,8'h3C, 0,0,3'd0,8'h00, 1,0);
        vt[11] = mk(1,0,3'd5,8'h00, 0,0,3'd0,8'h00, 1,0);
        vt[12] = mk(1,0,3'd6,8'h99, 0,0,3'd0,8'h00, 1,0);
        vt[13] = mk(0,0,3'd0,8'h00, 0,0,3'd0,8'h00, 0,0);
        vt[14] = mk(1,1,3'd4,8'h44, 1,1,3'd4,8'h55, 0,1);
        vt[15] = mk(1,1,3'd4,8'h44, 0,0,3'd0,8'h00, 1,0);
        vt[16] = mk(0,0,3'd0,8'h00, 1,0,3'd4,8'h00, 0,1);

        rst_n = 1'b0; rst_b_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
        b_addr0 = '0; b_addr1 = '0; b_data0 = '0; b_data1 = '0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst gnt0", 32'(gnt0), 32'd0);
        chk("rst gnt1", 32'(gnt1), 32'd0);
        chk("rst rvalid0", 32'(rvalid0), 32'd0);
        chk("rst q1", 32'(q1), 32'd0);
        chk("rst init_done", 32'(init_done), 32'd0);
        chk("rst mem_WE", 32'(mem_WE), 32'd0);
        chk("rst mem_Address", 32'(mem_Address), 32'd0);
        chk("rst mem_Data", 32'(mem_Data), 32'd0);

        // zero-fill with req0 held, then the held read is granted in cycle 9
        req0 = 1; we0 = 0; addr0 = 3'd0;
        rst_n = 1'b1;
        #1;
        chk("pre-edge mem_WE", 32'(mem_WE), 32'd0);
        run_init();
        step(mk(1,0,3'd0,8'h00, 0,0,3'd0,8'h00, 1,0));
        chk("init_done after fill", 32'(init_done), 32'd1);

        for (int i = 0; i < 17; i++) step(vt[i]);

        // reset pulled while a port-1 read is granted
        @(negedge clk);
        req0 = 0; req1 = 1; we1 = 0; addr1 = 3'd3;
        #1;
        chk("pre-reset gnt1", 32'(gnt1), 32'd1);
        #1;
        rst_n = 1'b0;
        exp_q0.delete(); exp_q1.delete();
        rv0_due = 1'b0; rv1_due = 1'b0;
        xq0_hold = '0; xq1_hold = '0;
        #1;
        chk("reset gnt1", 32'(gnt1), 32'd0);
        chk("reset init_done", 32'(init_done), 32'd0);
        chk("reset mem_WE", 32'(mem_WE), 32'd0);
        @(posedge clk);
        #1;
        chk("dropped rvalid1", 32'(rvalid1), 32'd0);
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 3'd2;
        req1 = 1; we1 = 0; addr1 = 3'd1;
        rst_n = 1'b1;
        #1;
        chk("re-release mem_WE", 32'(mem_WE), 32'd0);
        run_init();
        step(mk(1,0,3'd2,8'h00, 1,0,3'd1,8'h00, 1,0));
        step(mk(0,0,3'd0,8'h00, 1,0,3'd1,8'h00, 0,1));
        step(mk(0,0,3'd0,8'h00, 1,0,3'd3,8'h00, 0,1));
        step(mk(0,0,3'd0,8'h00, 0,0,3'd0,8'h00, 0,0));

        // depth 6 instance: 6-cycle fill, out-of-range write suppressed, read returns 0
        @(negedge clk);
        b_req0 = 1; b_we0 = 1; b_addr0 = 3'd7; b_data0 = 8'h77;
        rst_b_n = 1'b1;
        #1;
        chk("B pre-edge mem_WE", 32'(b_mem_WE), 32'd0);
        for (int i = 0; i < int'(DB); i++) begin
            @(negedge clk);
            #1;
            chk("B init mem_WE", 32'(b_mem_WE), 32'd1);
            chk("B init mem_Address", 32'(b_mem_Address), 32'(i));
            chk("B init gnt0", 32'(b_gnt0), 32'd0);
            chk("B init init_done", 32'(b_init_done), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("B init_done", 32'(b_init_done), 32'd1);
        chk("B oor write gnt0", 32'(b_gnt0), 32'd1);
        chk("B oor write mem_WE", 32'(b_mem_WE), 32'd0);
        chk("B oor mem_Address", 32'(b_mem_Address), 32'd7);
        @(negedge clk);
        b_we0 = 0;
        #1;
        chk("B oor read gnt0", 32'(b_gnt0), 32'd1);
        @(posedge clk);
        #1;
        chk("B oor rvalid0", 32'(b_rvalid0), 32'd1);
        chk("B oor q0", 32'(b_q0), 32'd0);
        @(negedge clk);
        b_addr0 = 3'd5;
        #1;
        chk("B read5 gnt0", 32'(b_gnt0), 32'd1);
        @(posedge clk);
        #1;
        chk("B read5 rvalid0", 32'(b_rvalid0), 32'd1);
        chk("B read5 q0", 32'(b_q0), 32'd0);
        @(negedge clk);
        b_req0 = 0;

        repeat (2) @(negedge clk);
        chk("q0 scoreboard drained", 32'(exp_q0.size()), 32'd0);
        chk("q1 scoreboard drained", 32'(exp_q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
